// File: rtl/i2c_slave_resp_pkg.sv
// Shared definitions for the i2c_slave_resp target: FSM state encodings,
// default bus address, ACK/NACK bit levels and an address-match helper.
package i2c_slave_resp_pkg;

    localparam logic [6:0] DEF_SLV_ADDR = 7'h50;

    // Level of the ninth (acknowledge) bit on the wire
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int ST_W = 4;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;

    // Address byte carries the 7-bit address in [7:1] and R/W in [0]
    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] slv_addr);
        return addr_byte[7:1] == slv_addr;
    endfunction

endpackage

// File: rtl/i2c_slave_resp_bus_sync.sv
// Brings scl/sda into the clk domain through 2-flop synchronizers and
// produces single-clk pulses for scl edges and START/STOP conditions.
module i2c_slave_resp_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda_in,
    output logic sda_s_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;

    logic scl_s;
    logic sda_s;
    logic sda_rise;
    logic sda_fall;

    // Synchronizer chains plus one history flop each for edge detection;
    // reset to the idle-bus level (high) so release does not fake an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl_s    = scl_sync_q[1];
    assign sda_s    = sda_sync_q[1];
    assign sda_rise = sda_s & ~sda_prev_q;
    assign sda_fall = ~sda_s & sda_prev_q;

    assign sda_s_o    = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    // sda may only move while scl is high for START/STOP
    assign start_o    = sda_fall & scl_s;
    assign stop_o     = sda_rise & scl_s;

endmodule

// File: rtl/i2c_slave_resp.sv
// I2C target: matches a 7-bit address, takes a register pointer as the first
// written byte, writes a DEPTH x 8 register file with auto-increment, and
// returns register bytes on reads. Never stretches scl.
//
// Bus handshake: data is sampled on scl rising edges (synchronized), and
// sda_oe only changes on the clk after a detected scl falling edge, so the
// wire is stable for the whole scl-high phase. START and STOP win over any
// state. dbg_state_o exposes the FSM state for observation.
module i2c_slave_resp
    import i2c_slave_resp_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = DEF_SLV_ADDR,
    parameter int         DEPTH    = 16,
    parameter int         AW       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            scl,
    input  logic            sda_in,
    output logic            sda_oe,
    output logic            busy,
    output logic            wr_stb,
    output logic [AW-1:0]   wr_addr,
    output logic [7:0]      wr_data,
    output logic [ST_W-1:0] dbg_state_o
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic bus_start;
    logic bus_stop;

    i2c_slave_resp_bus_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .scl        (scl),
        .sda_in     (sda_in),
        .sda_s_o    (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (bus_start),
        .stop_o     (bus_stop)
    );

    logic [ST_W-1:0] state_q,  state_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q,  shift_d;
    logic            rw_q,     rw_d;
    logic [AW-1:0]   ptr_q,    ptr_d;
    logic            sda_oe_q, sda_oe_d;
    logic            busy_q,   busy_d;
    // Set once the master ACKed a read byte; next scl_fall drives the new MSB
    logic            rack_q,   rack_d;
    logic            wr_stb_q, wr_stb_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            reg_we;

    logic [7:0]      regs_q [DEPTH];

    logic [7:0]      rx_byte;
    logic [AW-1:0]   ptr_inc;

    assign rx_byte = {shift_q[6:0], sda_s};
    assign ptr_inc = ptr_q + 1'b1;

    // Next-state logic for the protocol FSM and its datapath registers
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        rack_d    = rack_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        reg_we    = 1'b0;

        if (bus_stop) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            rack_d   = 1'b0;
        end else if (bus_start) begin
            // Repeated START keeps the pointer so a read can follow a pointer write
            state_d  = ST_ADDR;
            bitcnt_d = 3'd7;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            rack_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end

                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        if (bitcnt_q == 3'd0) begin
                            if (addr_match(rx_byte, SLV_ADDR)) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = rx_byte[0];
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            bitcnt_d = bitcnt_q - 1'b1;
                        end
                    end
                end

                // First scl_fall starts the ACK, second ends it
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (rw_q) begin
                            state_d  = ST_RDATA;
                            shift_d  = regs_q[ptr_q];
                            sda_oe_d = ~regs_q[ptr_q][7];
                            bitcnt_d = 3'd7;
                        end else begin
                            state_d  = ST_PTR;
                            sda_oe_d = 1'b0;
                            bitcnt_d = 3'd7;
                        end
                    end
                end

                ST_PTR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        if (bitcnt_q == 3'd0) begin
                            ptr_d   = rx_byte[AW-1:0];
                            state_d = ST_PTR_ACK;
                        end else begin
                            bitcnt_d = bitcnt_q - 1'b1;
                        end
                    end
                end

                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WDATA;
                            bitcnt_d = 3'd7;
                        end
                    end
                end

                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        if (bitcnt_q == 3'd0) begin
                            reg_we    = 1'b1;
                            wr_stb_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = rx_byte;
                            ptr_d     = ptr_inc;
                            state_d   = ST_WDATA_ACK;
                        end else begin
                            bitcnt_d = bitcnt_q - 1'b1;
                        end
                    end
                end

                // MSB is already on the wire; each scl_fall moves to the next bit
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RDATA_ACK;
                            rack_d   = 1'b0;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                            bitcnt_d = bitcnt_q - 1'b1;
                        end
                    end
                end

                ST_RDATA_ACK: begin
                    if (scl_rise && !rack_q) begin
                        ptr_d = ptr_inc;
                        if (sda_s == ACK) begin
                            shift_d = regs_q[ptr_inc];
                            rack_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall && rack_q) begin
                        state_d  = ST_RDATA;
                        sda_oe_d = ~shift_q[7];
                        bitcnt_d = 3'd7;
                        rack_d   = 1'b0;
                    end
                end

                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    // FSM and datapath state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= 3'd7;
            shift_q   <= 8'h00;
            rw_q      <= 1'b0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            rack_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            rack_q    <= rack_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Register file: cleared on reset, one byte written per completed WDATA byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (reg_we) begin
            regs_q[ptr_q] <= rx_byte;
        end
    end

    assign sda_oe      = sda_oe_q;
    assign busy        = busy_q;
    assign wr_stb      = wr_stb_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_slave_resp.sv
// Bench for i2c_slave_resp: a bit-banged I2C master drives the bus, and a
// transaction-level register model predicts write strobes and read data.
`timescale 1ns/1ps
module tb_i2c_slave_resp;
    import i2c_slave_resp_pkg::*;

    localparam int Q = 10;  // clk cycles per quarter scl period

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_wire;
    logic       sda_oe;
    logic       busy;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] dbg_state;

    always #5 clk = ~clk;

    // Open-drain wire: low if either side pulls
    assign sda_wire = sda_m & ~sda_oe;

    i2c_slave_resp #(.SLV_ADDR(7'h50), .DEPTH(16), .AW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .scl         (scl),
        .sda_in      (sda_wire),
        .sda_oe      (sda_oe),
        .busy        (busy),
        .wr_stb      (wr_stb),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  m_regs [16];
    int          m_ptr = 0;
    logic [7:0]  wbuf [8];
    logic        oe_seen = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Every write strobe must match the oldest predicted register write
    always @(negedge clk) begin
        if (reset && wr_stb) begin
            if (exp_q.size() == 0) begin
                check_eq("wr_stb_extra", 32'(wr_stb), 32'd0);
            end else begin
                check_eq("wr_stb_addr_data", {20'd0, wr_addr, wr_data}, {20'd0, exp_q.pop_front()});
            end
        end
        if (sda_oe) oe_seen = 1'b1;
    end

    initial begin
        #900us;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic q_wait();
        repeat (Q) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; q_wait();
        scl = 1'b1;   q_wait();
        sda_m = 1'b0; q_wait();
        scl = 1'b0;   q_wait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; q_wait();
        scl = 1'b1;   q_wait();
        sda_m = 1'b1; q_wait();
    endtask

    task automatic bus_bit(input logic b, output logic r);
        sda_m = b; q_wait();
        scl = 1'b1; q_wait();
        @(negedge clk) r = sda_wire;
        q_wait();
        scl = 1'b0; q_wait();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic r;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, r);
            b = {b[6:0], r};
        end
        bus_bit(nack, r);
    endtask

    task automatic set_pointer(input logic [7:0] p);
        logic ack;
        bus_start();
        write_byte(8'hA0, ack);
        check_eq("addr_w_ack", 32'(ack), 32'(ACK));
        check_eq("busy_after_match", 32'(busy), 32'd1);
        write_byte(p, ack);
        check_eq("ptr_ack", 32'(ack), 32'(ACK));
        m_ptr = p % 16;
    endtask

    task automatic frame_write(input logic [7:0] p, input int n);
        logic ack;
        set_pointer(p);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({4'(m_ptr), wbuf[i]});
            m_regs[m_ptr] = wbuf[i];
            m_ptr = (m_ptr + 1) % 16;
            write_byte(wbuf[i], ack);
            check_eq("data_ack", 32'(ack), 32'(ACK));
        end
        bus_stop();
        check_eq("wr_stb_pending", exp_q.size(), 0);
        check_eq("busy_after_stop", 32'(busy), 32'd0);
    endtask

    task automatic frame_read(input logic set_ptr, input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] b;
        if (set_ptr) set_pointer(p);
        bus_start();
        write_byte(8'hA1, ack);
        check_eq("addr_r_ack", 32'(ack), 32'(ACK));
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, b);
            check_eq("rd_data", 32'(b), 32'(m_regs[m_ptr]));
            m_ptr = (m_ptr + 1) % 16;
        end
        check_eq("busy_after_nack", 32'(busy), 32'd0);
        bus_stop();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       ack;
        logic       r;
        logic [7:0] b;
        logic [6:0] bad;

        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_sda_oe", 32'(sda_oe), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_wr_stb", 32'(wr_stb), 32'd0);
        check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_eq("rst_wr_data", 32'(wr_data), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b1;
        repeat (5) @(posedge clk);

        // Write two bytes at pointer 3
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        frame_write(8'h03, 2);

        // Pointer write, repeated START, read two bytes
        frame_read(1'b1, 8'h03, 2);

        // Foreign address: no ACK, no drive, no strobe
        oe_seen = 1'b0;
        bus_start();
        write_byte(8'h42, ack);
        check_eq("mismatch_ack", 32'(ack), 32'(NACK));
        write_byte(8'h55, ack);
        check_eq("mismatch_data_ack", 32'(ack), 32'(NACK));
        check_eq("mismatch_busy", 32'(busy), 32'd0);
        bus_stop();
        check_eq("mismatch_oe", 32'(oe_seen), 32'd0);

        // Pointer wrap from 15 to 0
        wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
        frame_write(8'h0F, 2);
        frame_read(1'b1, 8'h0F, 2);

        // STOP after four bits of a data byte discards it
        set_pointer(8'h07);
        for (int i = 0; i < 4; i++) bus_bit(1'b1, r);
        bus_stop();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("partial_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("partial_oe", 32'(sda_oe), 32'd0);
        check_eq("partial_busy", 32'(busy), 32'd0);
        check_eq("partial_no_stb", exp_q.size(), 0);
        frame_read(1'b0, 8'h00, 3);

        // Randomized frames, including pointer bytes with upper bits set
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                int n;
                n = $urandom_range(1, 4);
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
                frame_write(8'($urandom_range(0, 255)), n);
            end else begin
                frame_read(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                           $urandom_range(1, 4));
            end
        end

        // Random foreign addresses
        for (int k = 0; k < 3; k++) begin
            bad = 7'($urandom_range(0, 127));
            if (bad == 7'h50) bad = 7'h51;
            oe_seen = 1'b0;
            bus_start();
            write_byte({bad, 1'($urandom_range(0, 1))}, ack);
            check_eq("rand_mismatch_ack", 32'(ack), 32'(NACK));
            bus_stop();
            check_eq("rand_mismatch_oe", 32'(oe_seen), 32'd0);
        end

        // Asynchronous reset in the middle of a read byte
        wbuf[0] = 8'h3C;
        frame_write(8'h09, 1);
        set_pointer(8'h09);
        bus_start();
        write_byte(8'hA1, ack);
        check_eq("rst_rd_ack", 32'(ack), 32'(ACK));
        bus_bit(1'b1, r);
        check_eq("rst_rd_bit7", 32'(r), 32'd0);
        check_eq("rst_rd_driving", 32'(sda_oe), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_oe", 32'(sda_oe), 32'd0);
        check_eq("async_rst_busy", 32'(busy), 32'd0);
        check_eq("async_rst_wr_data", 32'(wr_data), 32'd0);
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        repeat (4) @(posedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        bus_stop();
        frame_read(1'b0, 8'h00, 3);
        frame_read(1'b1, 8'h09, 1);

        repeat (10) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
